// File: rtl/cpu_vram_wr_receiver_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
//   Shared definitions for the HPS-to-FPGA VRAM write receiver.
//   - VRAM_ADDR_W / VRAM_DATA_W / VRAM_BE_W : word address, data and
//     byte-enable widths of both the CPU-side and PPU-side write buses.
//   - VRAM_DEPTH : number of 64-bit words in the shadow buffer.
//   - vram_rx_state_t : receiver control states.
// ---------------------------------------------------------------------------
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 13;
    localparam int unsigned VRAM_DATA_W = 64;
    localparam int unsigned VRAM_BE_W   = 8;
    localparam int unsigned VRAM_DEPTH  = 1 << VRAM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2,
        DRAIN   = 2'd3
    } vram_rx_state_t;

endpackage : vram_pkg

// File: rtl/cpu_vram_wr_receiver_if.sv
// ---------------------------------------------------------------------------
// cpu_vram_wr_receiver_if
//   Bundles every non-clock signal of the VRAM write receiver.
//   Modports:
//     slave  : the receiver itself (consumes h2f_* / vblank_start, drives
//              cpu_wr_busy, vram_* and sync_done).
//     master : the surrounding SoC/PPU side (opposite directions).
//   Signals:
//     h2f_wraddr[12:0], h2f_wren, h2f_wrdata[63:0], h2f_byteena[7:0]
//                       : CPU write bus into the shadow buffer
//     h2f_wr_irq        : CPU frame-done request (rising edge significant)
//     vblank_start      : one-cycle pulse at start of vertical blank
//     cpu_wr_busy       : shadow buffer locked
//     vram_wraddr[12:0], vram_wren, vram_wrdata[63:0], vram_byteena[7:0]
//                       : PPU VRAM write port
//     sync_done         : one-cycle pulse when a copy completes
//     drop_cnt[15:0]    : dropped-write counter, present only when
//                         CPU_WR_DROP_CNT_EN is defined
// ---------------------------------------------------------------------------
interface cpu_vram_wr_receiver_if;
    import vram_pkg::*;

    logic [VRAM_ADDR_W-1:0] h2f_wraddr;
    logic                   h2f_wren;
    logic [VRAM_DATA_W-1:0] h2f_wrdata;
    logic [VRAM_BE_W-1:0]   h2f_byteena;
    logic                   h2f_wr_irq;
    logic                   vblank_start;

    logic                   cpu_wr_busy;
    logic [VRAM_ADDR_W-1:0] vram_wraddr;
    logic                   vram_wren;
    logic [VRAM_DATA_W-1:0] vram_wrdata;
    logic [VRAM_BE_W-1:0]   vram_byteena;
    logic                   sync_done;

`ifdef CPU_WR_DROP_CNT_EN
    logic [15:0]            drop_cnt;

    modport slave (
        input  h2f_wraddr, h2f_wren, h2f_wrdata, h2f_byteena,
        input  h2f_wr_irq, vblank_start,
        output cpu_wr_busy, vram_wraddr, vram_wren, vram_wrdata,
        output vram_byteena, sync_done, drop_cnt
    );

    modport master (
        output h2f_wraddr, h2f_wren, h2f_wrdata, h2f_byteena,
        output h2f_wr_irq, vblank_start,
        input  cpu_wr_busy, vram_wraddr, vram_wren, vram_wrdata,
        input  vram_byteena, sync_done, drop_cnt
    );
`else
    modport slave (
        input  h2f_wraddr, h2f_wren, h2f_wrdata, h2f_byteena,
        input  h2f_wr_irq, vblank_start,
        output cpu_wr_busy, vram_wraddr, vram_wren, vram_wrdata,
        output vram_byteena, sync_done
    );

    modport master (
        output h2f_wraddr, h2f_wren, h2f_wrdata, h2f_byteena,
        output h2f_wr_irq, vblank_start,
        input  cpu_wr_busy, vram_wraddr, vram_wren, vram_wrdata,
        input  vram_byteena, sync_done
    );
`endif

endinterface : cpu_vram_wr_receiver_if

// File: rtl/cpu_vram_wr_receiver_ram.sv
// ---------------------------------------------------------------------------
// shadow_vram_ram
//   Simple dual-port 8192 x 64 RAM holding the CPU's shadow copy of VRAM.
//   Write port is byte-enabled; read port is registered (1-cycle latency).
//   Contents are never reset; only the read data register is cleared so the
//   PPU-facing data output starts from zero.
//   Ports:
//     clk, rst_n            : clock, synchronous active-low reset (read reg)
//     wr_en, wr_addr,
//     wr_data, wr_be        : write port, wr_be[i] covers wr_data[8i+7:8i]
//     rd_en, rd_addr        : read request
//     rd_data               : read data, valid the cycle after rd_en
// ---------------------------------------------------------------------------
module shadow_vram_ram
    import vram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [VRAM_ADDR_W-1:0] wr_addr,
    input  logic [VRAM_DATA_W-1:0] wr_data,
    input  logic [VRAM_BE_W-1:0]   wr_be,
    input  logic                   rd_en,
    input  logic [VRAM_ADDR_W-1:0] rd_addr,
    output logic [VRAM_DATA_W-1:0] rd_data
);

    logic [VRAM_DATA_W-1:0] mem [VRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < VRAM_BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : shadow_vram_ram

// File: rtl/cpu_vram_wr_receiver.sv
// ---------------------------------------------------------------------------
// cpu_vram_wr_receiver
//   FPGA-side receiver of CPU VRAM writes. CPU writes land in a shadow RAM
//   while idle. A rising edge of h2f_wr_irq locks the buffer (cpu_wr_busy);
//   the next vblank_start bulk-copies words 0..COPY_WORDS-1 into the PPU
//   VRAM write port, then sync_done pulses and the lock is released.
//   Parameters:
//     COPY_WORDS : words copied per sync, 1..8192
//   Ports:
//     clk   : system clock
//     rst_n : synchronous active-low reset
//     bus   : cpu_vram_wr_receiver_if.slave (CPU bus in, PPU VRAM bus out,
//             busy / sync_done status)
//   Optional feature macro: CPU_WR_DROP_CNT_EN adds bus.drop_cnt, a
//   saturating count of CPU write cycles dropped while busy, cleared
//   together with each sync_done pulse.
// ---------------------------------------------------------------------------
module cpu_vram_wr_receiver
    import vram_pkg::*;
#(
    parameter int unsigned COPY_WORDS = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_vram_wr_receiver_if.slave bus
);

    localparam logic [VRAM_ADDR_W-1:0] LAST_ADDR = VRAM_ADDR_W'(COPY_WORDS - 1);

    vram_rx_state_t         state;
    logic                   irq_prev;
    logic [VRAM_ADDR_W-1:0] rd_cnt;
    logic                   irq_edge;
    logic                   wr_accept;
    logic                   rd_en;
    logic [VRAM_DATA_W-1:0] rd_data;

    always_comb begin
        irq_edge  = bus.h2f_wr_irq & ~irq_prev;
        wr_accept = bus.h2f_wren & (state == IDLE);
        rd_en     = (state == COPY);
    end

    shadow_vram_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (bus.h2f_wraddr),
        .wr_data (bus.h2f_wrdata),
        .wr_be   (bus.h2f_byteena),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    // The RAM's registered read data is the VRAM data register; address,
    // strobe and byte enables are registered here alongside it so all four
    // line up one cycle after the shadow read.
    always_comb begin
        bus.vram_wrdata = rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            irq_prev         <= 1'b0;
            rd_cnt           <= '0;
            bus.cpu_wr_busy  <= 1'b0;
            bus.sync_done    <= 1'b0;
            bus.vram_wren    <= 1'b0;
            bus.vram_wraddr  <= '0;
            bus.vram_byteena <= '0;
        end else begin
            irq_prev         <= bus.h2f_wr_irq;
            sync_done_clear();
            bus.vram_wren    <= rd_en;
            bus.vram_byteena <= rd_en ? '1 : '0;
            if (rd_en) begin
                bus.vram_wraddr <= rd_cnt;
            end

            unique case (state)
                IDLE: begin
                    // vblank_start in the same cycle is deliberately ignored.
                    if (irq_edge) begin
                        state           <= PENDING;
                        bus.cpu_wr_busy <= 1'b1;
                    end
                end
                PENDING: begin
                    if (bus.vblank_start) begin
                        state  <= COPY;
                        rd_cnt <= '0;
                    end
                end
                COPY: begin
                    // Counter stops at the last address rather than wrapping.
                    if (rd_cnt == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state           <= IDLE;
                    bus.cpu_wr_busy <= 1'b0;
                    bus.sync_done   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // sync_done is a single-cycle pulse; DRAIN re-asserts it above.
    function automatic void sync_done_clear();
        bus.sync_done <= 1'b0;
    endfunction

`ifdef CPU_WR_DROP_CNT_EN
    // Cleared while in DRAIN so the count reads 0 alongside sync_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.drop_cnt <= '0;
        end else if (state == DRAIN) begin
            bus.drop_cnt <= '0;
        end else if (bus.h2f_wren && (state != IDLE) && (bus.drop_cnt != '1)) begin
            bus.drop_cnt <= bus.drop_cnt + 1'b1;
        end
    end
`else
    // Dropped writes are discarded silently; no counter in this build.
`endif

endmodule : cpu_vram_wr_receiver

// File: doc/cpu_vram_wr_receiver.md
# cpu_vram_wr_receiver

FPGA-side receiving end of the HPS-to-FPGA VRAM write interface. Captures CPU VRAM writes (13-bit word address, 64-bit data, 8-bit byte enable) into a shadow buffer. On the CPU's frame-done interrupt, it raises `cpu_wr_busy`. At the next vertical-blank start it bulk-copies the shadow buffer into the PPU VRAM write port, then releases busy. Sits between the SoC's exported write interface and the PPU VRAM.

## Interface
Parameters:
- `COPY_WORDS`, 8192 — number of 64-bit words copied per sync (addresses 0..COPY_WORDS-1); range 1..8192.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `h2f_wraddr` in 13 — CPU write word address.
- `h2f_wren` in 1 — CPU write strobe, one word per cycle.
- `h2f_wrdata` in 64 — CPU write data.
- `h2f_byteena` in 8 — CPU byte enables; bit i covers data[8i+7:8i].
- `h2f_wr_irq` in 1 — CPU frame-done request; level, rising edge is significant.
- `vblank_start` in 1 — one-cycle pulse from the PPU at the start of vertical blank.
- `cpu_wr_busy` out 1 — shadow buffer locked; exported back to the CPU.
- `vram_wraddr` out 13 — PPU VRAM write address.
- `vram_wren` out 1 — PPU VRAM write strobe.
- `vram_wrdata` out 64 — PPU VRAM write data.
- `vram_byteena` out 8 — PPU VRAM byte enables; always 8'hFF when `vram_wren`=1.
- `sync_done` out 1 — one-cycle pulse when the copy completes.

## Operation
States:
- IDLE
  - CPU writes are applied to the shadow buffer with byte enables.
  - Rising edge of `h2f_wr_irq` moves to PENDING.
- PENDING
  - CPU writes are dropped.
  - `vblank_start` moves to COPY.
- COPY
  - A read counter issues shadow reads at 0..COPY_WORDS-1, one per cycle.
  - The next state is DRAIN after address COPY_WORDS-1 is issued.
- DRAIN
  - One cycle. The final word is written to VRAM.
  - Then `sync_done` pulses and the FSM returns to IDLE.

Rules:
- Edge detect: the registered previous value of `h2f_wr_irq` resets to 0. An irq held high through reset release counts as an edge.
- `cpu_wr_busy` = 1 in PENDING, COPY and DRAIN; 0 in IDLE.
- Dropped writes have no effect on the shadow buffer or on any output.
- VRAM write address and data are the shadow read address and read data, delayed by the 1-cycle RAM latency.
- The read counter is 13 bits, cleared on entry to COPY, and never wraps past COPY_WORDS-1.
- Simultaneous events:
  - `h2f_wren` in the same cycle as the irq edge (in IDLE): the write is accepted.
  - Irq edge and `vblank_start` in the same cycle in IDLE: go to PENDING only; the copy waits for the next vblank.
  - Irq edges in PENDING, COPY or DRAIN: ignored, not queued.
  - `vblank_start` in IDLE, COPY or DRAIN: ignored.
- Reset mid-copy:
  - Aborts the copy and returns to IDLE.
  - Shadow RAM contents are not reset; the partially written VRAM is left as is.

## Timing
- Reset values:
  - `cpu_wr_busy`=0, `vram_wren`=0, `vram_wraddr`=0, `vram_wrdata`=0, `vram_byteena`=0, `sync_done`=0.
  - State is IDLE.
- Irq rising edge seen at cycle t (IDLE) → `cpu_wr_busy`=1 from t+1.
- `vblank_start` at cycle v (PENDING) → first shadow read at v+1; `vram_wren`=1 with address 0 at v+2.
- The last VRAM write (address COPY_WORDS-1) is at v+COPY_WORDS+1, in DRAIN.
- `sync_done`=1 and `cpu_wr_busy`=0 at v+COPY_WORDS+2.
- `vram_wren` is high for exactly COPY_WORDS consecutive cycles; all VRAM outputs are registered.
- An accepted CPU write at cycle t is visible to a shadow read from t+1.

## Configuration
- `CPU_WR_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` (16 bits): a saturating count (max 16'hFFFF) of `h2f_wren` cycles dropped while busy.
  - Reset value 0; cleared on each `sync_done`.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `vram_pkg`:
  - Constants `VRAM_ADDR_W`=13, `VRAM_DATA_W`=64, `VRAM_BE_W`=8.
  - Enum `vram_rx_state_t` {IDLE, PENDING, COPY, DRAIN}.
- Sub-module `shadow_vram_ram`:
  - Simple dual-port RAM, 8192×64, with a byte-enabled write port and a registered read port (1-cycle latency).
  - No reset on contents.

## Test plan
- Write 0x0010 = 64'h1122334455667788 with byteena 8'hFF, then 0x0010 = 64'hAAAAAAAAAAAAAAAA with byteena 8'h0F. Then irq edge and vblank with COPY_WORDS=32 → VRAM address 0x0010 receives 64'h11223344AAAAAAAA.
- Irq edge at cycle t → `cpu_wr_busy` rises at t+1. A write to 0x0003 during PENDING is dropped; after the copy, VRAM address 3 holds the prior value. With the macro defined, `drop_cnt`=1 until `sync_done`.
- `vblank_start` at cycle v, COPY_WORDS=8192 → `vram_wren` high at v+2..v+8193 with addresses 0..8191 in order; `sync_done` and busy low at v+8194.
- Irq edge and `vblank_start` in the same IDLE cycle → no VRAM writes. The next `vblank_start` starts the copy.
- `rst_n`=0 at cycle 100 of the copy → next cycle all outputs are 0 and the state is IDLE. A new irq and vblank copy the full shadow contents correctly.
